// File: rtl/packet_read_sequencer_if.sv
// ----------------------------------------------------------------------------
// packet_read_sequencer_if
//   Word stream from the packet read sequencer to the host transport.
//   A word moves on a rising clock edge where out_valid and out_ready are both 1.
//
//   out_data   16-bit stream word
//   out_valid  out_data holds a word
//   out_ready  downstream can take the word this cycle
//   out_last   marks the final word of a packet
//   out_final  PacketFinal byte of the packet being streamed
//
//   master : sequencer side (drives data/valid/last/final, reads ready)
//   slave  : transport side (reads data/valid/last/final, drives ready)
// ----------------------------------------------------------------------------
interface packet_read_sequencer_if;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [7:0]  out_final;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        output out_final,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        input  out_final,
        output out_ready
    );
endinterface

// File: rtl/packet_read_sequencer.sv
// ----------------------------------------------------------------------------
// packet_read_sequencer
//   Read side of the TPIU packet collector. Opens one complete packet at a time
//   (PacketNext), fetches its words one by one (PacketNextWd), and presents each
//   word on a valid/ready stream. Counts packets that were fully forwarded.
//   A new packet only starts while enable and sync are both high; a packet
//   already in flight always runs to completion.
//
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   enable       allow new packets to start
//   sync         collector in-sync flag
//   PacketAvail  collector holds at least one complete packet
//   PacketNext   one-cycle strobe: open the next packet
//   PacketNextWd one-cycle strobe: fetch the next word of the open packet
//   PacketOut    collector word, valid the cycle after PacketNextWd
//   PacketFinal  final byte of the opened packet, valid the cycle after PacketNext
//   stream       word stream to the host transport (master modport)
//   busy         1 whenever the sequencer is not idle
//   pkt_count    packets fully forwarded, wraps silently
// ----------------------------------------------------------------------------
module packet_read_sequencer #(
    parameter int PKT_WORDS = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      sync,
    input  logic                      PacketAvail,
    output logic                      PacketNext,
    output logic                      PacketNextWd,
    input  logic [15:0]               PacketOut,
    input  logic [7:0]                PacketFinal,
    packet_read_sequencer_if.master   stream,
    output logic                      busy,
    output logic [CNT_WIDTH-1:0]      pkt_count
);

    localparam int IDX_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        OPEN,
        FETCH,
        CAP,
        SEND
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       wordIdx_q, wordIdx_d;
    logic [15:0]            outData_q, outData_d;
    logic                   outValid_q, outValid_d;
    logic                   outLast_q, outLast_d;
    logic [7:0]             outFinal_q, outFinal_d;
    logic [CNT_WIDTH-1:0]   pktCount_q, pktCount_d;

    logic startPacket;
    logic handshake;

    // enable and sync only gate the start of a packet, never one in flight
    assign startPacket = enable && sync && PacketAvail;
    assign handshake   = outValid_q && stream.out_ready;

    // State and datapath registers; reset abandons any packet in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wordIdx_q  <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            outFinal_q <= '0;
            pktCount_q <= '0;
        end else begin
            state_q    <= state_d;
            wordIdx_q  <= wordIdx_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            outLast_q  <= outLast_d;
            outFinal_q <= outFinal_d;
            pktCount_q <= pktCount_d;
        end
    end

    // Next-state logic; PacketAvail is only looked at in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (startPacket) state_d = OPEN;
            OPEN:    state_d = FETCH;
            FETCH:   state_d = CAP;
            CAP:     state_d = SEND;
            SEND:    if (handshake) state_d = outLast_q ? IDLE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Strobes. PacketNext is issued in the IDLE cycle that decides to start,
    // so PacketFinal is already valid during OPEN where it gets latched.
    // Both strobes are held off while reset is applied.
    always_comb begin
        PacketNext   = 1'b0;
        PacketNextWd = 1'b0;
        busy         = (state_q != IDLE);
        case (state_q)
            IDLE:    PacketNext   = startPacket && !rst;
            FETCH:   PacketNextWd = !rst;
            default: ;
        endcase
    end

    // Datapath next values: out_* only change in OPEN/CAP, or when a SEND
    // word is accepted, so they stay stable while the downstream stalls
    always_comb begin
        wordIdx_d  = wordIdx_q;
        outData_d  = outData_q;
        outValid_d = outValid_q;
        outLast_d  = outLast_q;
        outFinal_d = outFinal_q;
        pktCount_d = pktCount_q;
        case (state_q)
            OPEN: begin
                outFinal_d = PacketFinal;
                wordIdx_d  = '0;
            end
            CAP: begin
                outData_d  = PacketOut;
                outValid_d = 1'b1;
                outLast_d  = (wordIdx_q == LAST_IDX);
            end
            SEND: begin
                if (handshake) begin
                    outValid_d = 1'b0;
                    if (outLast_q) begin
                        pktCount_d = pktCount_q + CNT_WIDTH'(1);
                    end else begin
                        wordIdx_d = wordIdx_q + IDX_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign stream.out_data  = outData_q;
    assign stream.out_valid = outValid_q;
    assign stream.out_last  = outLast_q;
    assign stream.out_final = outFinal_q;
    assign pkt_count        = pktCount_q;

endmodule
